riscv_mem_responder: RTL and testbench



---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/riscv_mem_responder.sv | 110 +++++++++++
 tb/tb_riscv_mem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the data-memory responder.
package riscv_mem_pkg;

  // Access sizes, funct3 encoding of loads/stores.
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated data, load extension and
// misalignment / illegal-size detection. Purely combinational.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_ext_o,
  output logic        misalign_o
);

  logic [31:0] rdata_sh;

  // Move the addressed byte/halfword down to bit 0 for extension.
  assign rdata_sh = rdata_i >> {addr_lo_i, 3'b000};

  // Decode size into lane enables, write data and extended read data.
  always_comb begin
    be_o        = 4'b0000;
    wdata_o     = wd_i;
    rdata_ext_o = 32'h0;
    misalign_o  = 1'b0;
    case (size_i)
      LDST_B: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{wd_i[7:0]}};
        rdata_ext_o = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      end
      LDST_BU: begin
        // Unsigned sizes have no store meaning.
        misalign_o  = we_i;
        rdata_ext_o = {24'h0, rdata_sh[7:0]};
      end
      LDST_H: begin
        misalign_o  = addr_lo_i[0];
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o     = {2{wd_i[15:0]}};
        rdata_ext_o = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      end
      LDST_HU: begin
        misalign_o  = we_i | addr_lo_i[0];
        rdata_ext_o = {16'h0, rdata_sh[15:0]};
      end
      LDST_W: begin
        misalign_o  = (addr_lo_i != 2'b00);
        be_o        = 4'b1111;
        rdata_ext_o = rdata_i;
      end
      default: misalign_o = 1'b1;
    endcase
    if (misalign_o) begin
      be_o        = 4'b0000;
      rdata_ext_o = 32'h0;
    end
  end

endmodule

// File: rtl/riscv_mem_responder.sv
// Data-memory responder: wait-state FSM, stall generation and byte-lane RAM.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  mem_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [31:0]     mem_q [DEPTH];
  logic [IdxW-1:0] idx;
  logic [31:0]     rdata;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [31:0]     rdata_ext;
  logic            misalign;
  logic            done_acc;
  logic [3:0]      wr_be;
  logic            unused_addr;

  // Upper address bits are ignored: accesses wrap modulo DEPTH words.
  assign idx         = mem_addr_i[IdxW+1:2];
  assign unused_addr = ^mem_addr_i[31:IdxW+2];
  assign rdata       = mem_q[idx];

  mem_lane_align u_align (
    .size_i      (mem_size_i),
    .addr_lo_i   (mem_addr_i[1:0]),
    .we_i        (mem_we_i),
    .wd_i        (mem_wd_i),
    .rdata_i     (rdata),
    .be_o        (be),
    .wdata_o     (wdata),
    .rdata_ext_o (rdata_ext),
    .misalign_o  (misalign)
  );

  // State and wait-state counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: count LATENCY busy cycles, abort if the core drops the request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          state_d = BUSY;
          cnt_d   = CntInit;
        end
      end
      BUSY: begin
        if (!mem_req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion-cycle outputs; stall is combinational from the request.
  always_comb begin
    stall_o  = mem_req_i & (state_q != DONE);
    done_acc = (state_q == DONE) & mem_req_i;
    err_o    = done_acc & misalign;
    mem_rd_o = (done_acc & ~mem_we_i) ? rdata_ext : 32'h0;
    wr_be    = be & {4{done_acc & mem_we_i & ~misalign}};
  end

  // RAM with per-byte write enables; contents are not reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) begin
        mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Scoreboard bench for riscv_mem_responder.
module tb_riscv_mem_responder;
  import riscv_mem_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [2:0]  mem_size_i = 3'd0;
  logic [31:0] mem_addr_i = 32'h0;
  logic [31:0] mem_wd_i = 32'h0;
  logic [31:0] mem_rd_o;
  logic        stall_o;
  logic        err_o;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  riscv_mem_responder #(
    .DEPTH   (1024),
    .LATENCY (LAT)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .mem_size_i (mem_size_i),
    .mem_addr_i (mem_addr_i),
    .mem_wd_i   (mem_wd_i),
    .mem_rd_o   (mem_rd_o),
    .stall_o    (stall_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  // One full access; called just after a rising edge. Leaves req low afterwards.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input string name);
    exp_t e;
    int   n;
    bit   done;
    e.rd = exp_rd; e.err = exp_err; e.chk_rd = !we; e.name = name;
    sb.push_back(e);
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_addr_i = addr; mem_wd_i = wd;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < int'(LAT) + 10 && !done; c++) begin
      @(negedge clk_i);
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        n++;
        checks++;
        if (err_o !== 1'b0) begin
          errors++;
          $display("FAIL %s err_during_stall actual=%b required=0", name, err_o);
        end
      end
    end
    e = sb.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout stall never dropped", e.name);
    end else begin
      if (n !== int'(LAT) + 1) begin
        errors++;
        $display("FAIL %s stall_cycles actual=%0d required=%0d", e.name, n, LAT + 1);
      end
      checks++;
      if (err_o !== e.err) begin
        errors++;
        $display("FAIL %s err actual=%b required=%b", e.name, err_o, e.err);
      end
      if (e.chk_rd) begin
        checks++;
        if (mem_rd_o !== e.rd) begin
          errors++;
          $display("FAIL %s rd actual=%h required=%h", e.name, mem_rd_o, e.rd);
        end
      end
    end
    @(posedge clk_i);
    #1;
    mem_req_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (stall_o !== 1'b0 || err_o !== 1'b0 || mem_rd_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs actual=%b/%b/%h required=0/0/0", stall_o, err_o, mem_rd_o);
    end
    mem_req_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_follows_req actual=%b required=1", stall_o);
    end
    mem_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_word();
    access(1'b1, LDST_W, 32'h20, 32'h0, 32'h0, 1'b0, "sw_clear_20");
    access(1'b1, LDST_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
    access(1'b0, LDST_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
  endtask

  task automatic test_byte();
    access(1'b1, LDST_B, 32'h13, 32'h80, 32'h0, 1'b0, "sb_13");
    access(1'b0, LDST_B, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "lb_13");
    access(1'b0, LDST_BU, 32'h13, 32'h0, 32'h00000080, 1'b0, "lbu_13");
    access(1'b0, LDST_W, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "lw_10_after_sb");
  endtask

  task automatic test_half();
    access(1'b1, LDST_H, 32'h22, 32'h1234, 32'h0, 1'b0, "sh_22");
    access(1'b0, LDST_H, 32'h22, 32'h0, 32'h00001234, 1'b0, "lh_22");
    access(1'b0, LDST_W, 32'h20, 32'h0, 32'h12340000, 1'b0, "lw_20");
    access(1'b0, LDST_HU, 32'h12, 32'h0, 32'h000080AD, 1'b0, "lhu_12");
    access(1'b0, LDST_H, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0, "lh_12");
  endtask

  task automatic test_misalign();
    access(1'b0, LDST_W, 32'h11, 32'h0, 32'h0, 1'b1, "lw_11_misalign");
    access(1'b1, LDST_H, 32'h21, 32'hFFFF, 32'h0, 1'b1, "sh_21_misalign");
    access(1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, "load_size3");
    access(1'b1, LDST_BU, 32'h20, 32'hFF, 32'h0, 1'b1, "store_size4");
    access(1'b0, LDST_W, 32'h20, 32'h0, 32'h12340000, 1'b0, "lw_20_unchanged");
  endtask

  task automatic test_alias();
    access(1'b1, LDST_W, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b0, "sw_1000");
    access(1'b0, LDST_W, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, "lw_0_alias");
  endtask

  task automatic test_abort();
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = LDST_W;
    mem_addr_i = 32'h10; mem_wd_i = 32'h11111111;
    @(posedge clk_i);
    #1;
    mem_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs actual=%b/%b required=0/0", stall_o, err_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL abort_state actual=%0d required=%0d", dut.state_q, IDLE);
    end
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if (err_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_err actual=%b required=0", err_o);
      end
    end
    @(posedge clk_i);
    #1;
    access(1'b0, LDST_W, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "lw_10_after_abort");
  endtask

  task automatic test_reset_mid();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = LDST_W;
    mem_addr_i = 32'h10; mem_wd_i = 32'h0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (dut.state_q !== IDLE || stall_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid state/stall actual=%0d/%b required=%0d/1",
               dut.state_q, stall_o, IDLE);
    end
    mem_req_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || mem_rd_o !== 32'h0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_noreq actual=%b/%h/%b required=0/0/0", stall_o, mem_rd_o, err_o);
    end
    mem_req_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    access(1'b0, LDST_W, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "lw_10_after_rst");
  endtask

  task automatic test_back_to_back();
    access(1'b1, LDST_W, 32'h40, 32'hA5A55A5A, 32'h0, 1'b0, "b2b_sw_40");
    access(1'b0, LDST_W, 32'h40, 32'h0, 32'hA5A55A5A, 1'b0, "b2b_lw_40");
    access(1'b0, LDST_B, 32'h41, 32'h0, 32'h0000005A, 1'b0, "b2b_lb_41");
    access(1'b0, LDST_HU, 32'h42, 32'h0, 32'h0000A5A5, 1'b0, "b2b_lhu_42");
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_alias();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
